// File: rtl/fu_issue_sched_pkg.sv
// Shared definitions for the functional-unit issue scheduler: op classes and opcode constants.
package fu_issue_sched_pkg;

    // ALU opcode of the multiply; every other non-memory op executes on the ALU
    localparam logic [4:0] ALU_MULQ = 5'h0a;

    // Functional-unit class of an issued op
    typedef enum logic [1:0] {
        FuClassAlu  = 2'd0,
        FuClassMult = 2'd1,
        FuClassMem  = 2'd2
    } fu_class_e;

    // Memory ops take priority over the opcode, so a load carrying a MULQ opcode is still mem-class
    function automatic fu_class_e decode_class(input logic       rd_mem,
                                               input logic       wr_mem,
                                               input logic [4:0] alu_op);
        fu_class_e cls;
        if (rd_mem || wr_mem) begin
            cls = FuClassMem;
        end else if (alu_op == ALU_MULQ) begin
            cls = FuClassMult;
        end else begin
            cls = FuClassAlu;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fu_issue_sched_cdb_resv_shift.sv
// CDB reservation shift register. Bit k set means the CDB is claimed k cycles from now.
// Each cycle every reservation moves one slot closer to slot 0, masked slots are dropped,
// and new claims are ORed in at arbitrary slots.
module fu_issue_sched_cdb_resv_shift #(
    parameter int unsigned DEPTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DEPTH-1:0] flush_mask,
    input  logic [DEPTH-1:0] set_mask,
    output logic [DEPTH-1:0] resv
);

    logic [DEPTH-1:0] resv_q;
    logic [DEPTH-1:0] resv_d;
    logic [DEPTH-1:0] kept;

    // Advance reservations one slot, drop the masked ones, then merge the new claims
    always_comb begin
        kept   = {1'b0, resv_q[DEPTH-1:1]} & ~flush_mask;
        resv_d = kept | set_mask;
    end

    // Reservation state register
    always_ff @(posedge clk) begin
        if (reset) begin
            resv_q <= '0;
        end else begin
            resv_q <= resv_d;
        end
    end

    assign resv = resv_q;

    // A new claim landing on a slot that is already reserved would be a CDB collision
    a_no_collision: assert property (@(posedge clk) disable iff (reset)
        (kept & set_mask) == '0);

endmodule

// File: rtl/fu_issue_sched.sv
// Functional-unit issue scheduler. Produces the ex/mult/mem free signals that gate reservation
// station readiness, keeps ALU, multiplier and load results from colliding on the CDB,
// enforces the multiplier initiation interval and allows a single outstanding memory op.
module fu_issue_sched #(
    parameter int unsigned EX_LAT   = 1,
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned MULT_II  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_en,
    input  logic [4:0]        issue_ALUop,
    input  logic              issue_rd_mem,
    input  logic              issue_wr_mem,
    input  logic              mem_wb_req,
    input  logic              mem_done,
    input  logic              flush,
    output logic              ex_free,
    output logic              mult_free,
    output logic              mem_free,
    output logic              cdb_busy,
    output logic [MULT_LAT:0] resv_vec
);

    import fu_issue_sched_pkg::*;

    localparam int unsigned Depth = MULT_LAT + 1;
    localparam int unsigned IiW   = (MULT_II > 1) ? $clog2(MULT_II) : 1;

    localparam logic [IiW-1:0] IiReload = IiW'(MULT_II - 1);

    // Slots written by a new claim in the next-state vector
    localparam logic [Depth-1:0] AluSetSlot  = Depth'(1) << (EX_LAT - 1);
    localparam logic [Depth-1:0] MultSetSlot = Depth'(1) << (MULT_LAT - 1);
    localparam logic [Depth-1:0] WbSetSlot   = Depth'(1);

    // Slots an issue this cycle would land on, viewed in the current vector
    localparam logic [Depth-1:0] AluChkSlot  = Depth'(1) << EX_LAT;
    localparam logic [Depth-1:0] MultChkSlot = Depth'(1) << MULT_LAT;

    // A load writeback requested now claims the next cycle, which collides with a 1-cycle FU
    localparam bit ExLatOne   = (EX_LAT == 1);
    localparam bit MultLatOne = (MULT_LAT == 1);

    fu_class_e        issue_class;
    logic             alu_issue;
    logic             mult_issue;
    logic             mem_issue;
    logic [Depth-1:0] resv;
    logic [Depth-1:0] set_mask;
    logic [Depth-1:0] flush_mask;
    logic [IiW-1:0]   ii_cnt_q;
    logic [IiW-1:0]   ii_cnt_d;
    logic             mem_busy_q;
    logic             mem_busy_d;

    // Classify the issued op; issues in a flush cycle are squashed and claim nothing
    always_comb begin
        issue_class = decode_class(issue_rd_mem, issue_wr_mem, issue_ALUop);
        alu_issue   = issue_en && !flush && (issue_class == FuClassAlu);
        mult_issue  = issue_en && !flush && (issue_class == FuClassMult);
        mem_issue   = issue_en && !flush && (issue_class == FuClassMem);
    end

    // New CDB claims and the flush mask for the reservation shifter
    always_comb begin
        set_mask = '0;
        if (alu_issue) begin
            set_mask = set_mask | AluSetSlot;
        end
        if (mult_issue) begin
            set_mask = set_mask | MultSetSlot;
        end
        // Load data still returns after a squash, so its claim survives the flush
        if (mem_wb_req) begin
            set_mask = set_mask | WbSetSlot;
        end
        flush_mask = {Depth{flush}};
    end

    fu_issue_sched_cdb_resv_shift #(
        .DEPTH (Depth)
    ) u_resv_shift (
        .clk        (clk),
        .reset      (reset),
        .flush_mask (flush_mask),
        .set_mask   (set_mask),
        .resv       (resv)
    );

    // Next-state for the multiplier II counter and the memory-busy flag
    always_comb begin
        ii_cnt_d   = ii_cnt_q;
        mem_busy_d = mem_busy_q;

        if (flush) begin
            ii_cnt_d = '0;
        end else if (mult_issue) begin
            ii_cnt_d = IiReload;
        end else if (ii_cnt_q != '0) begin
            ii_cnt_d = ii_cnt_q - IiW'(1);
        end

        // The outstanding memory op survives a flush and still has to report done
        if (mem_issue) begin
            mem_busy_d = 1'b1;
        end else if (mem_done) begin
            mem_busy_d = 1'b0;
        end
    end

    // Scheduler state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ii_cnt_q   <= '0;
            mem_busy_q <= 1'b0;
        end else begin
            ii_cnt_q   <= ii_cnt_d;
            mem_busy_q <= mem_busy_d;
        end
    end

    // Free signals and debug outputs
    always_comb begin
        ex_free   = ((resv & AluChkSlot) == '0) && !(mem_wb_req && ExLatOne);
        mult_free = (ii_cnt_q == '0) && ((resv & MultChkSlot) == '0) &&
                    !(mem_wb_req && MultLatOne);
        mem_free  = !mem_busy_q;
        cdb_busy  = resv[0];
        resv_vec  = resv;
    end

    // Caller protocol checks; violations are not recovered
    a_alu_issue_free: assert property (@(posedge clk) disable iff (reset)
        !(issue_en && (issue_class == FuClassAlu) && !ex_free));
    a_mult_issue_free: assert property (@(posedge clk) disable iff (reset)
        !(issue_en && (issue_class == FuClassMult) && !mult_free));
    a_mem_issue_free: assert property (@(posedge clk) disable iff (reset)
        !(issue_en && (issue_class == FuClassMem) && !mem_free));
    a_mem_done_busy: assert property (@(posedge clk) disable iff (reset)
        !(mem_done && !mem_busy_q));
    a_mem_set_clr: assert property (@(posedge clk) disable iff (reset)
        !(mem_issue && mem_done));
    a_wb_slot_free: assert property (@(posedge clk) disable iff (reset)
        !(mem_wb_req && resv[1]));

endmodule

// File: tb/tb_fu_issue_sched.sv
// Directed bench for fu_issue_sched. CDB broadcasts are predicted into a scoreboard queue as ops
// are driven and compared against cdb_busy every cycle; free signals are checked at fixed points.
module tb_fu_issue_sched;

    import fu_issue_sched_pkg::*;

    localparam int unsigned EX_LAT   = 1;
    localparam int unsigned MULT_LAT = 4;
    localparam int unsigned MULT_II  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              issue_en;
    logic [4:0]        issue_ALUop;
    logic              issue_rd_mem;
    logic              issue_wr_mem;
    logic              mem_wb_req;
    logic              mem_done;
    logic              flush;
    logic              ex_free;
    logic              mult_free;
    logic              mem_free;
    logic              cdb_busy;
    logic [MULT_LAT:0] resv_vec;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int sb[$];

    logic [4:0] alu_ops [4] = '{5'h00, 5'h01, 5'h0b, 5'h1f};

    always #5 clk = ~clk;

    fu_issue_sched #(
        .EX_LAT   (EX_LAT),
        .MULT_LAT (MULT_LAT),
        .MULT_II  (MULT_II)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_en     (issue_en),
        .issue_ALUop  (issue_ALUop),
        .issue_rd_mem (issue_rd_mem),
        .issue_wr_mem (issue_wr_mem),
        .mem_wb_req   (mem_wb_req),
        .mem_done     (mem_done),
        .flush        (flush),
        .ex_free      (ex_free),
        .mult_free    (mult_free),
        .mem_free     (mem_free),
        .cdb_busy     (cdb_busy),
        .resv_vec     (resv_vec)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset        = 1'b0;
        issue_en     = 1'b0;
        issue_ALUop  = 5'h00;
        issue_rd_mem = 1'b0;
        issue_wr_mem = 1'b0;
        mem_wb_req   = 1'b0;
        mem_done     = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic push_claim(input int at);
        sb.push_back(at);
        sb.sort();
    endtask

    // Squashed or reset: broadcasts after the current cycle never happen
    task automatic drop_after();
        int keep[$];
        foreach (sb[i]) begin
            if (sb[i] <= cyc) keep.push_back(sb[i]);
        end
        sb = keep;
    endtask

    task automatic issue_alu(input logic [4:0] op);
        issue_en    = 1'b1;
        issue_ALUop = op;
        if (!reset && !flush) push_claim(cyc + EX_LAT);
    endtask

    task automatic issue_mulq();
        issue_en    = 1'b1;
        issue_ALUop = ALU_MULQ;
        if (!reset && !flush) push_claim(cyc + MULT_LAT);
    endtask

    // Memory ops carry the MULQ opcode to confirm the memory class takes priority
    task automatic issue_mem(input logic rd);
        issue_en     = 1'b1;
        issue_ALUop  = ALU_MULQ;
        issue_rd_mem = rd;
        issue_wr_mem = !rd;
    endtask

    task automatic wb_req();
        mem_wb_req = 1'b1;
        push_claim(cyc + 1);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        drop_after();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drop_after();
    endtask

    // Compare cdb_busy with the scoreboard, then advance one clock
    task automatic step();
        logic exp_busy;
        #1;
        exp_busy = 1'b0;
        while (sb.size() > 0 && sb[0] <= cyc) begin
            exp_busy = 1'b1;
            void'(sb.pop_front());
        end
        chk("cdb_busy_sb", {31'b0, cdb_busy}, {31'b0, exp_busy});
        @(posedge clk);
        #1;
        idle();
        #1;
        cyc++;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        idle();
        #1;
        cyc = 0;

        // Reset state
        chk("rst_ex_free", {31'b0, ex_free}, 32'd1);
        chk("rst_mult_free", {31'b0, mult_free}, 32'd1);
        chk("rst_mem_free", {31'b0, mem_free}, 32'd1);
        chk("rst_cdb_busy", {31'b0, cdb_busy}, 32'd0);
        chk("rst_resv_vec", {27'b0, resv_vec}, 32'd0);
        step();

        // MULQ: II blocks the next cycle, CDB claimed 4 cycles later, ALU blocked at t3
        chk("mulq_free_t0", {31'b0, mult_free}, 32'd1);
        issue_mulq();
        step();
        chk("mulq_ii_t1", {31'b0, mult_free}, 32'd0);
        step();
        chk("mulq_ii_t2", {31'b0, mult_free}, 32'd1);
        step();
        chk("alu_blocked_t3", {31'b0, ex_free}, 32'd0);
        step();
        chk("mulq_cdb_t4", {31'b0, cdb_busy}, 32'd1);
        step();

        // ALU: claim visible next cycle, back-to-back issue allowed
        issue_alu(5'h00);
        step();
        chk("alu_resv_t1", {27'b0, resv_vec}, 32'd1);
        chk("alu_cdb_t1", {31'b0, cdb_busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("alu_b2b_free", {31'b0, ex_free}, 32'd1);
            issue_alu(alu_ops[i]);
            step();
        end
        step();

        // Load: memory busy until the cycle after mem_done; writeback blocks ALU combinationally
        chk("ld_free_t0", {31'b0, mem_free}, 32'd1);
        issue_mem(1'b1);
        step();
        for (int i = 1; i < 5; i++) begin
            chk("ld_busy", {31'b0, mem_free}, 32'd0);
            chk("ld_not_mult", {31'b0, mult_free}, 32'd1);
            step();
        end
        wb_req();
        #1;
        chk("wb_blocks_ex_t5", {31'b0, ex_free}, 32'd0);
        chk("wb_mult_ok_t5", {31'b0, mult_free}, 32'd1);
        step();
        chk("wb_cdb_t6", {31'b0, cdb_busy}, 32'd1);
        chk("ld_busy_t6", {31'b0, mem_free}, 32'd0);
        mem_done = 1'b1;
        step();
        chk("ld_free_t7", {31'b0, mem_free}, 32'd1);
        step();

        // MULQ then flush: reservation and II are dropped
        issue_mulq();
        step();
        do_flush();
        step();
        chk("flush_resv_t2", {27'b0, resv_vec}, 32'd0);
        chk("flush_mult_t2", {31'b0, mult_free}, 32'd1);
        step();
        step();
        chk("flush_cdb_t4", {31'b0, cdb_busy}, 32'd0);
        step();

        // Store held across a flush until mem_done
        issue_mem(1'b0);
        step();
        chk("st_busy_t1", {31'b0, mem_free}, 32'd0);
        step();
        do_flush();
        step();
        chk("st_flush_busy", {31'b0, mem_free}, 32'd0);
        mem_done = 1'b1;
        step();
        chk("st_free_after_done", {31'b0, mem_free}, 32'd1);
        step();

        // Load with ALU traffic; writeback requested in the flush cycle is kept
        issue_mem(1'b1);
        step();
        issue_alu(5'h01);
        step();
        step();
        issue_alu(5'h1f);
        step();
        do_flush();
        wb_req();
        step();
        chk("flush_wb_resv", {27'b0, resv_vec}, 32'd1);
        mem_done = 1'b1;
        step();
        chk("flush_ld_free", {31'b0, mem_free}, 32'd1);
        step();

        // Reset mid-store with a multiply in flight; the ALU issue during reset is ignored
        issue_mem(1'b0);
        step();
        issue_mulq();
        step();
        do_reset();
        issue_alu(5'h00);
        step();
        chk("rst_mid_mem_free", {31'b0, mem_free}, 32'd1);
        chk("rst_mid_resv", {27'b0, resv_vec}, 32'd0);
        chk("rst_mid_mult_free", {31'b0, mult_free}, 32'd1);
        chk("rst_mid_ex_free", {31'b0, ex_free}, 32'd1);
        step();
        step();
        step();

        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
